// File: rtl/demux_1to8_deframer_if.sv
// Serial-in / parallel-out bus of the TDM deframer.
// The master drives the serial stream and the slave returns the recovered word.
interface demux_1to8_deframer_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
);
  logic             din;
  logic             din_valid;
  logic             din_sync;
  logic [N_CH-1:0]  dout;
  logic             dout_valid;
  logic             frame_err;
  logic [SEL_W-1:0] ch_sel;
  logic             busy;

  modport master (
    output din, din_valid, din_sync,
    input  dout, dout_valid, frame_err, ch_sel, busy
  );

  modport slave (
    input  din, din_valid, din_sync,
    output dout, dout_valid, frame_err, ch_sel, busy
  );
endinterface

// File: rtl/demux_1to8_deframer.sv
// TDM deframer: collects one serial bit per slot after a sync marker and
// presents the completed N_CH-bit frame with a one-cycle valid pulse.
module demux_1to8_deframer #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  demux_1to8_deframer_if.slave bus
);
  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_RECV   = 1'b1;
  localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  logic [0:0]       state_r, state_s;
  logic [SEL_W-1:0] slot_r, slot_s;
  // The last slot goes straight into dout, so shadow only holds slots 0..N_CH-2.
  logic [N_CH-2:0]  shadow_r, shadow_s;
  logic [N_CH-1:0]  dout_r, dout_s;
  logic             dout_valid_r, dout_valid_s;
  logic             frame_err_r, frame_err_s;

  // Next-state logic: nothing moves unless din_valid qualifies the slot.
  always_comb begin
    state_s      = state_r;
    slot_s       = slot_r;
    shadow_s     = shadow_r;
    dout_s       = dout_r;
    dout_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    if (bus.din_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.din_sync) begin
            shadow_s[0] = bus.din;
            slot_s      = SLOT_ONE;
            state_s     = ST_RECV;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RECV: begin
          if (bus.din_sync) begin
            // A sync inside a frame abandons it and restarts at slot 0.
            frame_err_s = 1'b1;
            shadow_s[0] = bus.din;
            slot_s      = SLOT_ONE;
          end else if (slot_r == SLOT_LAST) begin
            dout_s       = {bus.din, shadow_r};
            dout_valid_s = 1'b1;
            slot_s       = '0;
            state_s      = ST_IDLE;
          end else begin
            shadow_s[slot_r] = bus.din;
            slot_s           = slot_r + SLOT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          slot_s  = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; reset discards any partial frame and clears dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      slot_r       <= '0;
      shadow_r     <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      slot_r       <= slot_s;
      shadow_r     <= shadow_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.ch_sel     = slot_r;
  assign bus.busy       = (state_r == ST_RECV);
endmodule

// File: tb/tb_demux_1to8_deframer.sv
// Self-checking bench for demux_1to8_deframer: cycle table for a plain frame,
// then scoreboarded sequences for stalls, unsynced bits, aborts, back-to-back and reset.
module tb_demux_1to8_deframer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ferr_seen = 0;
  logic [7:0] exp_q[$];
  int   dv_cyc_q[$];

  demux_1to8_deframer_if bus ();

  demux_1to8_deframer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       din;
    logic       v;
    logic       s;
    logic [2:0] ch;
    logic       busy;
    logic       dv;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: every dout_valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_valid === 1'b1) begin
        dv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_dout_valid", 32'd1, 32'd0);
        end else begin
          chk("dout_word", {24'd0, bus.dout}, {24'd0, exp_q.pop_front()});
        end
      end
      if (bus.frame_err === 1'b1) ferr_seen++;
    end
  end

  task automatic step(input logic d, input logic v, input logic s);
    bus.din       = d;
    bus.din_valid = v;
    bus.din_sync  = s;
    @(posedge clk);
    #1;
  endtask

  // Full frame, sync on bit 0, optional stalls after slots 2 and 6.
  task automatic send_frame(input logic [7:0] w, input int g2, input int g6, input logic exp_ferr);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(w);
      step(w[k], 1'b1, (k == 0));
      if (k == 0) chk("frame_err_on_sync", {31'd0, bus.frame_err}, {31'd0, exp_ferr});
      if (k < 7) begin
        chk("ch_sel_mid", {29'd0, bus.ch_sel}, k + 1);
        chk("dv_mid", {31'd0, bus.dout_valid}, 32'd0);
      end else begin
        chk("dv_latency", {31'd0, bus.dout_valid}, 32'd1);
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
        chk("ch_sel_end", {29'd0, bus.ch_sel}, 32'd0);
      end
      if (k == 2) begin
        for (int g = 0; g < g2; g++) begin
          step(1'b1, 1'b0, 1'b1);
          chk("ch_sel_stall2", {29'd0, bus.ch_sel}, 32'd3);
        end
      end
      if (k == 6) begin
        for (int g = 0; g < g6; g++) begin
          step(1'b0, 1'b0, 1'b0);
          chk("ch_sel_stall6", {29'd0, bus.ch_sel}, 32'd7);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    w = 8'h52;
    for (int i = 0; i < 7; i++) begin
      tbl[i] = '{w[i], 1'b1, (i == 0), 3'(i + 1), 1'b1, 1'b0, 8'h00};
    end
    tbl[7] = '{w[7], 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h52};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h52};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h52};

    bus.din = 1'b0; bus.din_valid = 1'b0; bus.din_sync = 1'b0;
    #12;
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_dv", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_ch_sel", {29'd0, bus.ch_sel}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain 8'h52 frame, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].dv) exp_q.push_back(tbl[i].dout);
      step(tbl[i].din, tbl[i].v, tbl[i].s);
      chk("tbl_ch_sel", {29'd0, bus.ch_sel}, {29'd0, tbl[i].ch});
      chk("tbl_busy", {31'd0, bus.busy}, {31'd0, tbl[i].busy});
      chk("tbl_dv", {31'd0, bus.dout_valid}, {31'd0, tbl[i].dv});
      chk("tbl_dout", {24'd0, bus.dout}, {24'd0, tbl[i].dout});
    end

    // Stalls mid-frame.
    send_frame(8'h52, 3, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Unsynced bits are dropped silently.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("nosync_busy", {31'd0, bus.busy}, 32'd0);
      chk("nosync_ch_sel", {29'd0, bus.ch_sel}, 32'd0);
      chk("nosync_ferr", {31'd0, bus.frame_err}, 32'd0);
    end
    send_frame(8'hA5, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("a5_dout", {24'd0, bus.dout}, 32'h0000_00A5);

    // Sync at slot 4 aborts the 8'hFF frame.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("abort_ch_sel", {29'd0, bus.ch_sel}, 32'd4);
    send_frame(8'h3C, 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("abort_ferr_count", ferr_seen, 32'd1);
    chk("3c_dout", {24'd0, bus.dout}, 32'h0000_003C);

    // Back-to-back frames, no idle cycles.
    dv_cyc_q.delete();
    send_frame(8'h01, 0, 0, 1'b0);
    send_frame(8'h80, 0, 0, 1'b0);
    send_frame(8'hFF, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", dv_cyc_q.size(), 32'd3);
    if (dv_cyc_q.size() == 3) begin
      chk("b2b_gap1", dv_cyc_q[1] - dv_cyc_q[0], 32'd8);
      chk("b2b_gap2", dv_cyc_q[2] - dv_cyc_q[1], 32'd8);
    end

    // Asynchronous reset at slot 5.
    send_frame(8'h52, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_ch_sel", {29'd0, bus.ch_sel}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", {24'd0, bus.dout}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_ch_sel", {29'd0, bus.ch_sel}, 32'd0);
    #4;
    rst_n = 1'b1;
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    send_frame(8'h0F, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("0f_dout", {24'd0, bus.dout}, 32'h0000_000F);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("ferr_total", ferr_seen, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1to8_deframer.md
Name: demux_1to8_deframer

Overview:
- Receive-end counterpart of the team's 8:1 selector: a serial TDM stream (one channel bit per slot) is demultiplexed back into an 8-bit parallel word.
- An internal slot counter replaces the external select. A per-frame sync marks slot 0.
- Sits after a serialiser/mux stage. Delivers one word per frame with a one-cycle valid pulse, plus a resync error flag.

Parameters:
- N_CH, 8, number of channels/slots per frame (bits per output word); must be >= 2.
- SEL_W, 3, width of slot counter; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion synchronous to clk.
- din  input  1  serial channel bit for current slot.
- din_valid  input  1  din is sampled on this clk edge; low = stall, all state held.
- din_sync  input  1  qualified by din_valid; marks din as slot 0 of a new frame.
- dout  output  N_CH  last complete frame; bit k = channel/slot k.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- frame_err  output  1  one-cycle pulse when a sync aborts a partial frame.
- ch_sel  output  SEL_W  slot index the next valid bit will be written to.
- busy  output  1  high while in RECV (partial frame held).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slot=0, shadow=0, dout=0, dout_valid=0, frame_err=0. ch_sel=0, busy=0. Reset mid-frame discards the partial frame. dout is cleared.
- Sample condition: a bit is accepted only on a clk edge with din_valid=1. din_sync with din_valid=0 is ignored.
- Bit order: first bit of frame (sync bit) goes to dout[0], the k-th bit to dout[k].
- dout_valid and frame_err default to 0 every cycle unless set below.
- IDLE:
  - valid & sync: shadow[0]<=din, slot<=1, go RECV.
  - valid & !sync: bit discarded, stay IDLE, no flag.
- RECV, valid & !sync, slot < N_CH-1: shadow[slot]<=din, slot<=slot+1.
- RECV, valid & !sync, slot == N_CH-1:
  - dout<={din, shadow[N_CH-2:0]}, dout_valid<=1.
  - slot<=0, go IDLE.
- RECV, valid & sync (any slot >= 1):
  - partial frame discarded, frame_err<=1, dout unchanged.
  - shadow[0]<=din, slot<=1, stay RECV (new frame starts).
- Latency: dout/dout_valid are visible in the cycle after the edge that samples the last bit, i.e. 1 clk after last bit presented.
- Back-to-back frames: sync on the cycle immediately after the last bit is accepted (IDLE path). No dead cycle required; throughput = 1 bit/clk.
- Stalls: any number of din_valid=0 cycles mid-frame hold slot/shadow unchanged. No timeout.
- dout holds its value between frames; only a complete frame or reset changes it.
- ch_sel = slot register; busy = (state==RECV). Both are registered, with no combinational path from inputs.
- Shadow bits above the current slot are don't-care and never visible on dout.

Test Plan:
- Reset, then frame 8'h52 sent slot0 first (bits 0,1,0,0,1,0,1,0), sync on first, continuous valid.
  - Required: dout=8'h52 and dout_valid=1 for exactly one cycle, 1 clk after the 8th bit. ch_sel sequence is 0..7 then 0. busy falls with dout_valid.
- Same 8'h52 frame with din_valid low for 3 cycles after slot 2 and 1 cycle after slot 6.
  - Required: dout=8'h52, dout_valid delayed by 4 cycles. ch_sel holds during gaps.
- Three bits (1,1,1) sent with no sync, then frame 8'hA5 with sync.
  - Required: the unsynced bits are ignored, no frame_err, dout=8'hA5.
- Frame begun with 8'hFF bits, sync reasserted at slot 4, then full frame 8'h3C.
  - Required: frame_err pulse on that edge +1, no dout_valid for the aborted frame. dout=8'h3C afterwards.
- Back-to-back frames 8'h01, 8'h80, 8'hFF with no idle cycles.
  - Required: three dout_valid pulses exactly 8 clks apart, with those values in order.
- rst_n dropped asynchronously (between edges) at slot 5 of a frame following a completed 8'h52.
  - Required: dout=0, busy=0, ch_sel=0 immediately. A subsequent full frame 8'h0F yields dout=8'h0F.
